dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL expose one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL have port `clk`: input, 1 bit, rising-edge clock.
REQ-003 SHALL have port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port `DMread`: input, 1 bit, load request from the pipeline; held until accepted.
REQ-005 SHALL have port `DMwriteEn`: input, 1 bit, store request from the pipeline; held until accepted.
REQ-006 SHALL have port `cpu_addr`: input, 32 bits, word-aligned byte address; bits [1:0] are ignored.
REQ-007 SHALL have port `cpu_wdata`: input, 32 bits, store data.
REQ-008 SHALL have port `cpu_rdata`: output, 32 bits, load data, valid when `DMread`=1 and `cache_busy`=0.
REQ-009 SHALL have port `cache_busy`: output, 1 bit, pipeline stall request consumed by the control unit.
REQ-010 SHALL have port `mem_req`: output, 1 bit, backing-memory request.
REQ-011 SHALL have port `mem_we`: output, 1 bit, 1 = write, 0 = read.
REQ-012 SHALL have port `mem_addr`: output, 32 bits, word-aligned backing address.
REQ-013 SHALL have port `mem_wdata`: output, 32 bits, backing write data.
REQ-014 SHALL have port `mem_ack`: input, 1 bit, one-cycle completion pulse, honoured only while `mem_req`=1.
REQ-015 SHALL have port `mem_rdata`: input, 32 bits, read data, valid in the `mem_ack` cycle.
REQ-016 SHALL have parameter `LINES`, default 16, number of direct-mapped one-word lines (power of 2).

Function
REQ-017 SHALL decode the address as index = `cpu_addr[IDX_W+1:2]` and tag = `cpu_addr[31:IDX_W+2]`, where IDX_W = log2(LINES).
REQ-018 SHALL define a read hit as: line valid and stored tag equal to the request tag.
REQ-019 SHALL use the FSM states IDLE, MEM_RD, MEM_WR and WR_DONE.
REQ-020 SHALL, in IDLE with `DMread`=1 and a hit, drive `cpu_rdata` combinationally with the line data and hold `cache_busy` at 0 (zero-stall load).
REQ-021 SHALL, in IDLE with `DMread`=1 and a miss, assert `cache_busy` in the same cycle, latch the address, and move to MEM_RD.
REQ-022 SHALL, in MEM_RD, drive `mem_req`=1 and `mem_we`=0, and hold `mem_addr` stable until `mem_ack`.
REQ-023 SHALL, on the `mem_ack` cycle in MEM_RD, write valid, tag and data into the line and move to IDLE.
REQ-024 SHALL let the still-held load hit on the next cycle, giving a miss latency of memory latency + 1 stall cycle.
REQ-025 SHALL, in IDLE with `DMwriteEn`=1, follow a write-through, no-write-allocate policy:
  - assert `cache_busy` in the same cycle;
  - latch address and data;
  - if the tag hits, update the line data in that cycle; if it misses, leave the line unchanged;
  - move to MEM_WR.
REQ-026 SHALL, in MEM_WR, drive `mem_req`=1 and `mem_we`=1 with the latched address and data; on `mem_ack`, move to WR_DONE.
REQ-027 SHALL, in WR_DONE, drive `cache_busy`=0 for exactly one cycle, ignore all requests (the store retires), and return to IDLE.
REQ-028 SHALL give `DMwriteEn` priority when `DMread` and `DMwriteEn` are both 1.
REQ-029 SHALL hold `cache_busy` at 1 throughout MEM_RD and MEM_WR.
REQ-030 SHALL hold `cache_busy` at 0 in IDLE when there is no request or on a read hit.
REQ-031 SHALL ignore `mem_ack` while `mem_req`=0.
REQ-032 SHALL keep `mem_req` at 0 in IDLE and WR_DONE.
REQ-033 SHALL keep `mem_addr` and `mem_wdata` stable from `mem_req` rise until `mem_ack`.
REQ-034 SHALL treat `cpu_rdata` as don't-care when it is not qualified; the implementation drives the indexed line data.

Reset
REQ-035 SHALL, on `rst`=1 at a rising edge, clear all valid bits, set state to IDLE, and clear the latched address and data to 0.
REQ-036 SHALL hold outputs at `cache_busy`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0 and `mem_wdata`=0 while in reset.
REQ-037 SHALL, on reset during MEM_RD or MEM_WR, abandon the transaction and drop `mem_req` in the following cycle.
REQ-038 SHALL ignore a late `mem_ack` after a reset-abandoned transaction, so the line is not filled.

Structure
REQ-039 SHALL place the FSM state enum, IDX_W and TAG_W derivation, and the default LINES in shared package `dcache_pkg`.
REQ-040 SHALL place tag, valid and data storage in sub-module `dcache_array`:
  - asynchronous read;
  - synchronous write;
  - synchronous valid clear on `rst`.
REQ-041 SHALL keep the FSM and memory handshake in `dcache_ctrl`.

Verification
REQ-042 SHALL cover a cold load miss: `DMread` at 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 cycles gives `cache_busy`=1 for 4 cycles, then `cpu_rdata`=0xDEAD_BEEF with `cache_busy`=0.
REQ-043 SHALL cover a repeat load hit: a second `DMread` at 0x0000_0040 gives `cache_busy`=0 in the request cycle, `cpu_rdata`=0xDEAD_BEEF, and no `mem_req`.
REQ-044 SHALL cover a store hit:
  - stimulus: `DMwriteEn` at 0x0000_0040 with data 0x1234_5678;
  - response: one `mem_req`/`mem_we`=1 beat, a single WR_DONE cycle with `cache_busy`=0, and a following load hit returning 0x1234_5678.
REQ-045 SHALL cover a conflict miss: a load at 0x0000_0080 (same index 0, different tag) misses and refills, after which 0x0000_0040 misses again.
REQ-046 SHALL cover reset mid-read-miss:
  - stimulus: `rst` asserted in MEM_RD, then `mem_ack` delivered;
  - response: `mem_req`=0 next cycle, the line stays invalid, and a subsequent load at the same address misses.
REQ-047 SHALL cover simultaneous requests: `DMread` and `DMwriteEn` both 1 issues a memory write only (`mem_we`=1).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped, write-through data cache.
package dcache_pkg;

    localparam int LINES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_RD  = 2'd1,
        MEM_WR  = 2'd2,
        WR_DONE = 2'd3
    } state_t;

    // Index covers bits [IDX_W+1:2]; the tag is whatever remains of the word address.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return 30 - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: asynchronous read, synchronous write, valid bits cleared on reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEFAULT,
    localparam int IDX_W = idx_w(LINES),
    localparam int TAG_W = tag_w(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: an invalid line is never reported as a hit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped one-word-line data cache controller: zero-stall load hits,
// blocking refill on load miss, write-through / no-write-allocate stores.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DMread,
    input  logic        DMwriteEn,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cache_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES);

    state_t      state_q, state_d;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;

    logic             busy_c, req_c, we_c, latch_en;
    logic             arr_we;
    logic [IDX_W-1:0] arr_idx;
    logic [TAG_W-1:0] arr_tag;
    logic [31:0]      arr_data;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign req_idx = cpu_addr[IDX_W+1:2];
    assign req_tag = cpu_addr[31:IDX_W+2];
    assign hit     = rd_valid && (rd_tag == req_tag);

    dcache_array #(.LINES(LINES)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (arr_we && !rst),
        .wr_idx   (arr_idx),
        .wr_tag   (arr_tag),
        .wr_data  (arr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_q  <= cpu_addr[31:2];
                wdata_q <= cpu_wdata;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_c   = 1'b0;
        req_c    = 1'b0;
        we_c     = 1'b0;
        latch_en = 1'b0;
        arr_we   = 1'b0;
        arr_idx  = addr_q[IDX_W-1:0];
        arr_tag  = addr_q[29:IDX_W];
        arr_data = mem_rdata;
        unique case (state_q)
            IDLE: begin
                if (DMwriteEn) begin
                    busy_c   = 1'b1;
                    latch_en = 1'b1;
                    // Write-through: refresh a resident copy, never allocate on a store miss.
                    if (hit) begin
                        arr_we   = 1'b1;
                        arr_idx  = req_idx;
                        arr_tag  = req_tag;
                        arr_data = cpu_wdata;
                    end
                    state_d = MEM_WR;
                end else if (DMread && !hit) begin
                    busy_c   = 1'b1;
                    latch_en = 1'b1;
                    state_d  = MEM_RD;
                end
            end
            MEM_RD: begin
                busy_c = 1'b1;
                req_c  = 1'b1;
                if (mem_ack) begin
                    arr_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            MEM_WR: begin
                busy_c = 1'b1;
                req_c  = 1'b1;
                we_c   = 1'b1;
                if (mem_ack) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                // Store retires here; the held request must not start a second store.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata  = rd_data;
    assign cache_busy = busy_c && !rst;
    assign mem_req    = req_c && !rst;
    assign mem_we     = we_c && !rst;
    assign mem_addr   = rst ? 32'd0 : {addr_q, 2'b00};
    assign mem_wdata  = rst ? 32'd0 : wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: transaction table plus hand-written reset sequences.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        DMread, DMwriteEn;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cache_busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    dcache_ctrl #(.LINES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .DMread     (DMread),
        .DMwriteEn  (DMwriteEn),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cache_busy (cache_busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_busy;
        int          exp_req;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t tbl[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic        auto_mem;
    int          mem_lat, mem_cnt;
    int          beat_cnt;
    logic        beat_we;
    logic [31:0] beat_addr, beat_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_A5A5;
    endfunction

    // Advance one clock; the backing-memory model answers after mem_lat cycles of mem_req.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (auto_mem && mem_req) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ack    = 1'b1;
                mem_rdata  = mem_rd(mem_addr);
                mem_cnt    = 0;
                beat_cnt++;
                beat_we    = mem_we;
                beat_addr  = mem_addr;
                beat_wdata = mem_wdata;
                if (mem_we) mem_model[mem_addr] = mem_wdata;
            end
        end else if (!mem_req) begin
            mem_cnt = 0;
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input int eb,
                       input int er, input logic [31:0] erd);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.lat = lat;
        t.exp_busy = eb; t.exp_req = er; t.exp_rdata = erd;
        tbl.push_back(t);
    endtask

    // Called at posedge+1; holds the request until cache_busy drops, then releases it.
    task automatic run_txn(input txn_t t, input int k);
        int busy_n, req_n, n;
        string tag;
        tag       = $sformatf("txn%0d", k);
        DMread    = t.rd;
        DMwriteEn = t.wr;
        cpu_addr  = t.addr;
        cpu_wdata = t.wdata;
        mem_lat   = t.lat;
        mem_cnt   = 0;
        beat_cnt  = 0;
        busy_n    = 0;
        req_n     = 0;
        n         = 0;
        #3;
        while (cache_busy && n < 50) begin
            busy_n++;
            if (mem_req) begin
                req_n++;
                chk({tag, "_mem_addr_stable"}, mem_addr, t.addr & 32'hFFFF_FFFC);
            end
            tick();
            #3;
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: cache_busy still 1 after %0d cycles, expected release", tag, n);
        end
        chk({tag, "_busy_cycles"}, busy_n, t.exp_busy);
        chk({tag, "_req_cycles"}, req_n, t.exp_req);
        chk({tag, "_req_at_release"}, {31'd0, mem_req}, 32'd0);
        if (t.rd && !t.wr) chk({tag, "_rdata"}, cpu_rdata, t.exp_rdata);
        if (t.exp_req > 0) begin
            chk({tag, "_beats"}, beat_cnt, 1);
            chk({tag, "_beat_we"}, {31'd0, beat_we}, {31'd0, t.wr});
            chk({tag, "_beat_addr"}, beat_addr, t.addr & 32'hFFFF_FFFC);
            if (t.wr) chk({tag, "_beat_wdata"}, beat_wdata, t.wdata);
        end
        tick();
        DMread    = 1'b0;
        DMwriteEn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; DMread = 1'b1; DMwriteEn = 1'b0;
        cpu_addr = 32'h40; cpu_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        auto_mem = 1'b1; mem_lat = 1; mem_cnt = 0; beat_cnt = 0;
        beat_we = 1'b0; beat_addr = '0; beat_wdata = '0;
        mem_model[32'h40] = 32'hDEAD_BEEF;
        mem_model[32'h80] = 32'hCAFE_F00D;

        //     rd    wr    addr           wdata          lat busy req rdata
        add(1'b1, 1'b0, 32'h0000_0040, 32'h0,          3,  4,  3, 32'hDEAD_BEEF);
        add(1'b1, 1'b0, 32'h0000_0040, 32'h0,          3,  0,  0, 32'hDEAD_BEEF);
        add(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678,  2,  3,  2, 32'h0);
        add(1'b1, 1'b0, 32'h0000_0040, 32'h0,          1,  0,  0, 32'h1234_5678);
        add(1'b1, 1'b0, 32'h0000_0080, 32'h0,          2,  3,  2, 32'hCAFE_F00D);
        add(1'b1, 1'b0, 32'h0000_0080, 32'h0,          1,  0,  0, 32'hCAFE_F00D);
        add(1'b1, 1'b0, 32'h0000_0040, 32'h0,          1,  2,  1, 32'h1234_5678);
        add(1'b0, 1'b1, 32'h0000_0044, 32'h55AA_55AA,  1,  2,  1, 32'h0);
        add(1'b1, 1'b0, 32'h0000_0044, 32'h0,          1,  2,  1, 32'h55AA_55AA);
        add(1'b1, 1'b1, 32'h0000_0048, 32'h0BAD_F00D,  1,  2,  1, 32'h0);
        add(1'b1, 1'b0, 32'h0000_0048, 32'h0,          1,  2,  1, 32'h0BAD_F00D);
        add(1'b1, 1'b0, 32'h0000_003C, 32'h0,          1,  2,  1, 32'hA5A5_A599);
        add(1'b1, 1'b0, 32'h0000_007C, 32'h0,          1,  2,  1, 32'hA5A5_A5D9);
        add(1'b1, 1'b0, 32'h0000_007F, 32'h0,          1,  0,  0, 32'hA5A5_A5D9);
        add(1'b1, 1'b0, 32'h0000_003C, 32'h0,          2,  3,  2, 32'hA5A5_A599);
        add(1'b1, 1'b0, 32'hFFFF_FFC0, 32'h0,          2,  3,  2, 32'h5A5A_5A65);

        // Reset with a load pending: everything quiet.
        tick();
        tick();
        #3;
        chk("rst_busy", {31'd0, cache_busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        DMread = 1'b0;
        tick();

        foreach (tbl[i]) run_txn(tbl[i], i);

        // Reset in the middle of a read refill; a late ack must not fill the line.
        auto_mem = 1'b0;
        DMread = 1'b1;
        cpu_addr = 32'h0000_0100;
        #3;
        chk("rstmid_busy_req_cycle", {31'd0, cache_busy}, 32'd1);
        tick();
        #3;
        chk("rstmid_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rstmid_mem_addr", mem_addr, 32'h0000_0100);
        tick();
        #3;
        chk("rstmid_mem_addr_hold", mem_addr, 32'h0000_0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        DMread = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_1111;
        #3;
        chk("rstmid_req_dropped", {31'd0, mem_req}, 32'd0);
        chk("rstmid_busy_after", {31'd0, cache_busy}, 32'd0);
        tick();
        auto_mem = 1'b1;
        begin
            txn_t t;
            t.rd = 1'b1; t.wr = 1'b0; t.addr = 32'h0000_0100; t.wdata = 32'h0; t.lat = 1;
            t.exp_busy = 2; t.exp_req = 1; t.exp_rdata = 32'hA5A5_A4A5;
            run_txn(t, 100);
            t.addr = 32'h0000_0040; t.lat = 3;
            t.exp_busy = 4; t.exp_req = 3; t.exp_rdata = 32'h1234_5678;
            run_txn(t, 101);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
